md_seq: RTL and testbench

- Multiply/divide sequencer for the five-stage pipeline, living alongside the E stage.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E and models a multi-cycle unit with a busy countdown.
- Owns the HI/LO registers and generates the stall request for D-stage instructions that touch HI/LO while the unit is occupied.

---
 rtl/md_seq.sv | 144 ++++++++++++++
 tb/tb_md_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_seq.sv
// Multiply/divide sequencer: owns HI/LO, models a multi-cycle unit and raises the D-stage stall.
// Optional macro MD_CANCEL_EN adds E_Cancel to kill an in-flight mult/div or suppress a start.
module md_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_Start,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_UseMD,
`ifdef MD_CANCEL_EN
  input  logic        E_Cancel,
`endif
  output logic [31:0] E_Out,
  output logic        E_Busy,
  output logic        Stall_MD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, BUSY} state_t;

  // A zero cycle count would never leave BUSY cleanly, so it is promoted to one.
  localparam logic [3:0] MULT_LOAD = (MULT_CYCLES < 1) ? 4'd1 : 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = (DIV_CYCLES  < 1) ? 4'd1 : 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pHi;
  logic [31:0] pLo;
  logic        pWrite;
  logic        cancel;

  logic [63:0]        prodS;
  logic [63:0]        prodU;
  logic [31:0]        divisor;
  logic signed [31:0] quotS;
  logic signed [31:0] remS;
  logic [31:0]        quotU;
  logic [31:0]        remU;
  logic               isMulDiv;

`ifdef MD_CANCEL_EN
  assign cancel = E_Cancel;
`else
  assign cancel = 1'b0;
`endif

  assign prodS   = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
  assign prodU   = {32'd0, E_A} * {32'd0, E_B};
  // Divisor is forced nonzero so the datapath never divides by zero; the result is discarded anyway.
  assign divisor = (E_B == 32'd0) ? 32'd1 : E_B;
  assign quotS   = $signed(E_A) / $signed(divisor);
  assign remS    = $signed(E_A) % $signed(divisor);
  assign quotU   = E_A / divisor;
  assign remU    = E_A % divisor;

  assign isMulDiv = (E_MDOp >= 4'd1) && (E_MDOp <= 4'd4);
  assign E_Busy   = (state == BUSY);
  assign Stall_MD = D_UseMD & (E_Busy | (E_Start & isMulDiv));

  always_comb begin
    E_Out = 32'd0;
    case (E_MDOp)
      4'd7:    E_Out = HI;
      4'd8:    E_Out = LO;
      default: E_Out = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      pHi    <= 32'd0;
      pLo    <= 32'd0;
      pWrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (E_Start && !cancel) begin
            case (E_MDOp)
              4'd1: begin
                {pHi, pLo} <= prodS;
                pWrite     <= 1'b1;
                cnt        <= MULT_LOAD;
                state      <= BUSY;
              end
              4'd2: begin
                {pHi, pLo} <= prodU;
                pWrite     <= 1'b1;
                cnt        <= MULT_LOAD;
                state      <= BUSY;
              end
              4'd3: begin
                pHi    <= remS;
                pLo    <= quotS;
                pWrite <= (E_B != 32'd0);
                cnt    <= DIV_LOAD;
                state  <= BUSY;
              end
              4'd4: begin
                pHi    <= remU;
                pLo    <= quotU;
                pWrite <= (E_B != 32'd0);
                cnt    <= DIV_LOAD;
                state  <= BUSY;
              end
              4'd5:    HI <= E_A;
              4'd6:    LO <= E_A;
              default: ;
            endcase
          end
        end
        BUSY: begin
          // Starts arriving here are ignored; a kill takes priority over the final commit.
          if (cancel) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt <= 4'd1) begin
            if (pWrite) begin
              HI <= pHi;
              LO <= pLo;
            end
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_seq.sv
// Directed bench for md_seq: vector table for arithmetic/HI-LO ops plus stall, reset and cancel sequences.
// Build with +define+MD_CANCEL_EN to exercise the cancel port.
module tb_md_seq;

  logic        clk;
  logic        reset;
  logic        E_Start;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_UseMD;
  logic        E_Cancel;
  logic [31:0] E_Out;
  logic        E_Busy;
  logic        Stall_MD;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int errors;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expBusy;
  } vec_t;

  vec_t vecs[10];

  md_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_Start  (E_Start),
    .E_MDOp   (E_MDOp),
    .E_A      (E_A),
    .E_B      (E_B),
    .D_UseMD  (D_UseMD),
`ifdef MD_CANCEL_EN
    .E_Cancel (E_Cancel),
`endif
    .E_Out    (E_Out),
    .E_Busy   (E_Busy),
    .Stall_MD (Stall_MD),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // One-cycle start pulse, then count the busy cycles (bounded).
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int busy);
    @(negedge clk);
    E_Start = 1'b1;
    E_MDOp  = op;
    E_A     = a;
    E_B     = b;
    @(posedge clk);
    #1;
    E_Start = 1'b0;
    E_MDOp  = 4'd0;
    busy    = 0;
    while (E_Busy && busy < 40) begin
      busy++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int busy;
    logic [31:0] savedHi;
    logic [31:0] savedLo;
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    E_Start  = 1'b0;
    E_MDOp   = 4'd0;
    E_A      = 32'd0;
    E_B      = 32'd0;
    D_UseMD  = 1'b0;
    E_Cancel = 1'b0;

    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{4'd5, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0};
    vecs[5] = '{4'd6, 32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 0};
    vecs[6] = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[7] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8] = '{4'd9, 32'h55555555, 32'h1,        32'h00000001, 32'hFFFFFFFD, 0};
    vecs[9] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resetHI", HI, 32'd0);
    checkOutput("resetLO", LO, 32'd0);
    checkOutput("resetBusy", {31'd0, E_Busy}, 32'd0);
    checkOutput("resetStall", {31'd0, Stall_MD}, 32'd0);
    E_MDOp = 4'd7;
    #1;
    checkOutput("resetMfhi", E_Out, 32'd0);
    E_MDOp = 4'd0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, busy);
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d HI", i), HI, vecs[i].expHi);
      checkOutput($sformatf("vec%0d LO", i), LO, vecs[i].expLo);
      E_MDOp = 4'd7;
      #1;
      checkOutput($sformatf("vec%0d mfhi", i), E_Out, vecs[i].expHi);
      E_MDOp = 4'd8;
      #1;
      checkOutput($sformatf("vec%0d mflo", i), E_Out, vecs[i].expLo);
      E_MDOp = 4'd0;
    end

    // Stall held from the start cycle through every busy cycle, released after commit.
    @(negedge clk);
    D_UseMD = 1'b1;
    E_Start = 1'b1;
    E_MDOp  = 4'd1;
    E_A     = 32'd3;
    E_B     = 32'd4;
    #1;
    checkOutput("stallStart", {31'd0, Stall_MD}, 32'd1);
    @(posedge clk);
    #1;
    E_Start = 1'b0;
    E_MDOp  = 4'd0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stallBusy%0d", i), {30'd0, E_Busy, Stall_MD}, 32'd3);
      @(posedge clk);
      #1;
    end
    checkOutput("stallRelease", {30'd0, E_Busy, Stall_MD}, 32'd0);
    E_MDOp = 4'd8;
    #1;
    checkOutput("stallMflo", E_Out, 32'd12);
    E_MDOp  = 4'd0;
    D_UseMD = 1'b0;

    // Async reset in the third busy cycle of a div discards the pending result.
    applyStimulus(4'd5, 32'h0BADF00D, 32'd0, busy);
    @(negedge clk);
    E_Start = 1'b1;
    E_MDOp  = 4'd3;
    E_A     = 32'hFFFFFFF9;
    E_B     = 32'd2;
    @(posedge clk);
    #1;
    E_Start = 1'b0;
    E_MDOp  = 4'd0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("preResetBusy", {31'd0, E_Busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midResetBusy", {31'd0, E_Busy}, 32'd0);
    checkOutput("midResetHI", HI, 32'd0);
    checkOutput("midResetLO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("postResetHI", HI, 32'd0);
    checkOutput("postResetLO", LO, 32'd0);

`ifdef MD_CANCEL_EN
    applyStimulus(4'd5, 32'hAAAA0000, 32'd0, busy);
    applyStimulus(4'd6, 32'h00005555, 32'd0, busy);
    savedHi = 32'hAAAA0000;
    savedLo = 32'h00005555;
    @(negedge clk);
    E_Start = 1'b1;
    E_MDOp  = 4'd1;
    E_A     = 32'd2;
    E_B     = 32'd2;
    @(posedge clk);
    #1;
    E_Start = 1'b0;
    E_MDOp  = 4'd0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("cancelCycle5Busy", {31'd0, E_Busy}, 32'd1);
    E_Cancel = 1'b1;
    @(posedge clk);
    #1;
    E_Cancel = 1'b0;
    checkOutput("cancelBusy", {31'd0, E_Busy}, 32'd0);
    checkOutput("cancelHI", HI, savedHi);
    checkOutput("cancelLO", LO, savedLo);
    @(negedge clk);
    E_Start  = 1'b1;
    E_MDOp   = 4'd5;
    E_A      = 32'h00000001;
    E_Cancel = 1'b1;
    @(posedge clk);
    #1;
    E_Start  = 1'b0;
    E_MDOp   = 4'd0;
    E_Cancel = 1'b0;
    checkOutput("cancelMthiHI", HI, savedHi);
    checkOutput("cancelMthiBusy", {31'd0, E_Busy}, 32'd0);
`else
    savedHi = HI;
    savedLo = LO;
    applyStimulus(4'd1, 32'd2, 32'd2, busy);
    checkOutput("noCancelBusy", 32'(busy), 32'd5);
    checkOutput("noCancelHI", HI, 32'd0);
    checkOutput("noCancelLO", LO, 32'd4);
    checkOutput("noCancelPrevHI", savedHi, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
